// File: rtl/seq_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_div_pkg
//  Description : Shared types and constants for the sequential divider.
//                Divider state encoding, default operand width and the
//                iteration-counter width derived from it.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_div_pkg;

    // Default operand / quotient / remainder width
    localparam int SEQ_DIV_WIDTH = 8;

    // Iteration counter width: must hold WIDTH-1
    localparam int CTR_W = $clog2(SEQ_DIV_WIDTH) + 1;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : seq_div_pkg
`default_nettype wire

// File: rtl/seq_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : seq_div_step
//  Description : One radix-2 restoring-division step. Shifts {rem,quo}
//                left by one, trial-subtracts the divisor from the widened
//                partial remainder and keeps the difference when it does
//                not go negative, shifting the outcome bit into quo.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    // Shifted partial remainder needs one extra bit before the subtract
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, i_div});
    assign w_diff  = w_shift - {1'b0, i_div};

    // Restoring choice: keep the difference only when it is non-negative.
    // In both cases the result is below the divisor, so WIDTH bits suffice.
    assign o_rem = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule : seq_div_step
`default_nettype wire

// File: rtl/seq_div_8bit.sv
`default_nettype none
// ============================================================================
//  Module      : seq_div_8bit
//  Description : Iterative radix-2 restoring divider, one quotient bit per
//                clock. Accepts a/b on start, returns q/r with rdy held
//                until the next accepted start. Divide by zero returns
//                q = all ones, r = a with dbz set.
//                Build option SEQ_DIV_SIGNED_EN: when defined, operands are
//                signed two's complement (truncating division, remainder
//                takes the dividend's sign) and a FIX state applies signs;
//                when undefined, operands are unsigned and CALC goes
//                straight to DONE.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_div_8bit
    import seq_div_pkg::*;
#(
    parameter int WIDTH = SEQ_DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             rdy,
    output logic             busy,
    output logic             dbz
);

    localparam int                 c_CTR_W    = $clog2(WIDTH) + 1;
    localparam logic [c_CTR_W-1:0] c_CTR_LAST = c_CTR_W'(WIDTH - 1);

    state_t             r_state;
    logic [c_CTR_W-1:0] r_ctr;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;

    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

`ifdef SEQ_DIV_SIGNED_EN
    logic r_sa;
    logic r_sb;

    // Magnitudes as WIDTH-bit unsigned values, so |-2^(W-1)| is exact
    assign w_mag_a = a[WIDTH-1] ? (-a) : a;
    assign w_mag_b = b[WIDTH-1] ? (-b) : b;
`else
    assign w_mag_a = a;
    assign w_mag_b = b;
`endif

    // Single shared step datapath, reused every CALC cycle
    seq_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    // Control FSM, work registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ctr   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
`ifdef SEQ_DIV_SIGNED_EN
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
`endif
            q       <= '0;
            r       <= '0;
            rdy     <= 1'b0;
            busy    <= 1'b0;
            dbz     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_rem <= '0;
                        r_quo <= w_mag_a;
                        r_div <= w_mag_b;
                        r_ctr <= '0;
`ifdef SEQ_DIV_SIGNED_EN
                        r_sa  <= a[WIDTH-1];
                        r_sb  <= b[WIDTH-1];
`endif
                        if (b == '0) begin
                            // Zero divisor completes immediately
                            r_state <= DONE;
                            q       <= '1;
                            r       <= a;
                            rdy     <= 1'b1;
                            dbz     <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= CALC;
                            rdy     <= 1'b0;
                            dbz     <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                end

                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_ctr <= r_ctr + 1'b1;
                    if (r_ctr == c_CTR_LAST) begin
`ifdef SEQ_DIV_SIGNED_EN
                        r_state <= FIX;
`else
                        // Unsigned result is final after the last step
                        r_state <= DONE;
                        q       <= w_quo_nxt;
                        r       <= w_rem_nxt;
                        rdy     <= 1'b1;
                        busy    <= 1'b0;
`endif
                    end
                end

`ifdef SEQ_DIV_SIGNED_EN
                FIX: begin
                    // Quotient negative when signs differ; remainder follows dividend
                    q       <= (r_sa ^ r_sb) ? (-r_quo) : r_quo;
                    r       <= r_sa ? (-r_rem) : r_rem;
                    r_state <= DONE;
                    rdy     <= 1'b1;
                    busy    <= 1'b0;
                end
`endif

                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : seq_div_8bit
`default_nettype wire

// File: tb/tb_seq_div_8bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_div_8bit
//  Description : Self-checking bench for seq_div_8bit. Table of directed
//                vectors, hand sequences for reset / ignored start / held
//                start, and random operands against an arithmetic model.
//                Follows SEQ_DIV_SIGNED_EN in the same way as the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_div_8bit;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       rdy;
    logic       busy;
    logic       dbz;

    int checks;
    int errors;

`ifdef SEQ_DIV_SIGNED_EN
    localparam int c_LAT = 10;
`else
    localparam int c_LAT = 9;
`endif
    localparam int c_TIMEOUT = 40;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } vec_t;

    vec_t tbl[$];

    seq_div_8bit u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .rdy   (rdy),
        .busy  (busy),
        .dbz   (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Division as defined arithmetically: truncating toward zero,
    // remainder with the dividend's sign, results modulo 256
    task automatic model(input logic [7:0] ma, input logic [7:0] mb,
                         output logic [7:0] mq, output logic [7:0] mr, output logic md);
        int ia;
        int ib;
        if (mb == 8'd0) begin
            mq = 8'hFF;
            mr = ma;
            md = 1'b1;
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            ia = $signed(ma);
            ib = $signed(mb);
`else
            ia = int'(ma);
            ib = int'(mb);
`endif
            mq = 8'(ia / ib);
            mr = 8'(ia % ib);
            md = 1'b0;
        end
    endtask

    // Start one operation and wait for rdy; lat counts sample points after
    // the accepting edge, so rdy after edge N+k is seen at lat = k+1
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic ed, input string nm);
        int lat;
        @(negedge clk);
        a     = ta;
        b     = tb_;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        if (!ed) check({nm, "_busy"}, busy, 1'b1);
        while (!rdy && lat < c_TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_lat"}, lat, ed ? 1 : c_LAT);
        check({nm, "_q"},   q,   eq);
        check({nm, "_r"},   r,   er);
        check({nm, "_dbz"}, dbz, ed);
    endtask

    initial begin
        logic [7:0] mq;
        logic [7:0] mr;
        logic       md;
        logic [7:0] ra;
        logic [7:0] rb;
        int         lat;
        int         pulses;
        int         run;
        int         maxrun;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        a      = 8'd0;
        b      = 8'd0;

`ifdef SEQ_DIV_SIGNED_EN
        tbl.push_back('{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0});
        tbl.push_back('{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0});
        tbl.push_back('{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0});
        tbl.push_back('{8'd5,   8'd0,   8'hFF, 8'h05, 1'b1});
        tbl.push_back('{8'd9,   8'd3,   8'h03, 8'h00, 1'b0});
        tbl.push_back('{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0});
        tbl.push_back('{8'h80,  8'h01,  8'h80, 8'h00, 1'b0});
        tbl.push_back('{8'hFF,  8'h02,  8'h00, 8'hFF, 1'b0});
        tbl.push_back('{8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0});
        tbl.push_back('{8'hF6,  8'h00,  8'hFF, 8'hF6, 1'b1});
`else
        tbl.push_back('{8'd200, 8'd3,   8'd66,  8'd2,  1'b0});
        tbl.push_back('{8'd5,   8'd0,   8'hFF,  8'd5,  1'b1});
        tbl.push_back('{8'd9,   8'd3,   8'd3,   8'd0,  1'b0});
        tbl.push_back('{8'd255, 8'd1,   8'd255, 8'd0,  1'b0});
        tbl.push_back('{8'd0,   8'd7,   8'd0,   8'd0,  1'b0});
        tbl.push_back('{8'd7,   8'd255, 8'd0,   8'd7,  1'b0});
        tbl.push_back('{8'd255, 8'd255, 8'd1,   8'd0,  1'b0});
        tbl.push_back('{8'd1,   8'd2,   8'd0,   8'd1,  1'b0});
        tbl.push_back('{8'd128, 8'd128, 8'd1,   8'd0,  1'b0});
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_q",    q,    8'd0);
        check("rst_r",    r,    8'd0);
        check("rst_rdy",  rdy,  1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dbz",  dbz,  1'b0);

        // start together with reset: reset wins
        a     = 8'd9;
        b     = 8'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_start_busy", busy, 1'b0);
        check("rst_start_rdy",  rdy,  1'b0);
        start = 1'b0;
        reset = 1'b0;

        // Directed table
        foreach (tbl[i])
            do_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz, $sformatf("tbl%0d", i));

        // Reset asserted so it is sampled at edge N+4 of a busy run
        @(negedge clk);
        a     = 8'd100;
        b     = 8'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_q",    q,    8'd0);
        check("midrst_r",    r,    8'd0);
        check("midrst_rdy",  rdy,  1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_dbz",  dbz,  1'b0);
        do_op(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, "after_rst");

        // A second start while busy is ignored
        @(negedge clk);
        a     = 8'd100;
        b     = 8'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        @(negedge clk);
        lat++;
        a     = 8'd60;
        b     = 8'd9;
        start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!rdy && lat < c_TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        check("ign_lat", lat, c_LAT);
        check("ign_q",   q,   8'd14);
        check("ign_r",   r,   8'd2);

        // Start in DONE accepted: rdy drops on the next cycle
        do_op(8'd60, 8'd9, 8'd6, 8'd6, 1'b0, "from_done");

        // start held high in DONE: rdy pulses for one cycle per result
        @(negedge clk);
        a      = 8'd9;
        b      = 8'd3;
        start  = 1'b1;
        pulses = 0;
        run    = 0;
        maxrun = 0;
        repeat (4 * c_LAT) begin
            @(negedge clk);
            if (rdy) begin
                if (run == 0) pulses++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        start = 1'b0;
        check("held_pulses", pulses, 4);
        check("held_width",  maxrun, 1);
        check("held_q",      q,      8'd3);

        // Random operands against the model
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            model(ra, rb, mq, mr, md);
            do_op(ra, rb, mq, mr, md, $sformatf("rnd%0d_%0h_%0h", i, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_div_8bit
`default_nettype wire
